// File: rtl/bit_count_pkg.sv
// Shared types for the bit-count engine: FSM state encoding and count-mode selector.
package bit_count_pkg;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} bc_state_t;

  typedef enum logic {MODE_ONES, MODE_ZEROS} bc_mode_t;

endpackage

// File: rtl/bit_count_engine_if.sv
// Start/done handshake and result bus between the operand source and the bit-count engine.
interface bit_count_engine_if #(
  parameter int DATA_W = 8
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              start;
  logic              mode;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  result;
  logic [DATA_W-1:0] curr_a;

  modport master (
    output start, mode, data_in,
    input  busy, done, result, curr_a
  );

  modport slave (
    input  start, mode, data_in,
    output busy, done, result, curr_a
  );

endinterface

// File: rtl/bit_count_engine_popcount_slice.sv
// Combinational population count of a W-bit slice.
module popcount_slice #(
  parameter int W = 1
) (
  input  logic [W-1:0]             in_i,
  output logic [$clog2(W+1)-1:0]   count_o
);
  localparam int CW = $clog2(W + 1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CW'(in_i[i]);
    end
  end

endmodule

// File: rtl/bit_count_engine.sv
// Bit-count engine: loads an operand on start, counts ones (or zeros) BITS_PER_CYCLE bits
// per cycle, stops early once the remaining operand is zero, then holds done until start drops.
module bit_count_engine
  import bit_count_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  bit_count_engine_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PC_W  = $clog2(BITS_PER_CYCLE + 1);

  if (DATA_W < 1 || BITS_PER_CYCLE < 1 || (DATA_W % BITS_PER_CYCLE) != 0) begin : g_bad_params
    $error("bit_count_engine: DATA_W must be >= 1 and a multiple of BITS_PER_CYCLE");
  end

  bc_state_t         state_q, state_d;
  logic              busy_q, done_q;
  logic [CNT_W-1:0]  result_q, result_d;
  logic [DATA_W-1:0] curr_a_q, curr_a_d;
  logic [PC_W-1:0]   slice_cnt;

  popcount_slice #(.W(BITS_PER_CYCLE)) u_slice (
    .in_i    (curr_a_q[BITS_PER_CYCLE-1:0]),
    .count_o (slice_cnt)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    curr_a_d = curr_a_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Counting zeros is counting ones of the inverted operand.
          curr_a_d = (bc_mode_t'(bus.mode) == MODE_ZEROS) ? ~bus.data_in : bus.data_in;
          result_d = '0;
          state_d  = S_COUNT;
        end
      end
      S_COUNT: begin
        if (curr_a_q == '0) begin
          state_d = S_DONE;
        end else begin
          result_d = result_q + CNT_W'(slice_cnt);
          curr_a_d = curr_a_q >> BITS_PER_CYCLE;
        end
      end
      S_DONE: begin
        // Four-phase handshake: wait for start to fall before re-arming.
        if (!bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      curr_a_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d == S_COUNT);
      done_q   <= (state_d == S_DONE);
      result_q <= result_d;
      curr_a_q <= curr_a_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.curr_a = curr_a_q;

endmodule

// File: tb/tb_bit_count_engine.sv
// Directed bench for bit_count_engine: an 8-bit/1-bit-per-cycle and a 16-bit/4-bit-per-cycle instance.
module tb_bit_count_engine;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  bit_count_engine_if #(.DATA_W(8))  ifa ();
  bit_count_engine_if #(.DATA_W(16)) ifb ();

  bit_count_engine #(.DATA_W(8), .BITS_PER_CYCLE(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  bit_count_engine #(.DATA_W(16), .BITS_PER_CYCLE(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_a(input string tag, input logic m, input logic [7:0] d,
                       input int exp_res, input int exp_lat);
    int n;
    ifa.mode    = m;
    ifa.data_in = d;
    ifa.start   = 1'b1;
    tick();
    check({tag, " busy"}, 32'(ifa.busy), 32'd1);
    n = 0;
    while (!ifa.done && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " result"}, 32'(ifa.result), 32'(exp_res));
    tick();
    check({tag, " done held"}, 32'(ifa.done), 32'd1);
    ifa.start = 1'b0;
    tick();
    check({tag, " done drop"}, 32'(ifa.done), 32'd0);
    check({tag, " result kept"}, 32'(ifa.result), 32'(exp_res));
  endtask

  task automatic run_b(input string tag, input logic [15:0] d,
                       input int exp_res, input int exp_lat);
    int n;
    ifb.mode    = 1'b0;
    ifb.data_in = d;
    ifb.start   = 1'b1;
    tick();
    n = 0;
    while (!ifb.done && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " result"}, 32'(ifb.result), 32'(exp_res));
    ifb.start = 1'b0;
    tick();
    check({tag, " done drop"}, 32'(ifb.done), 32'd0);
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    ifa.start   = 1'b0;
    ifa.mode    = 1'b0;
    ifa.data_in = '0;
    ifb.start   = 1'b0;
    ifb.mode    = 1'b0;
    ifb.data_in = '0;

    // Reset held two cycles
    tick();
    tick();
    check("rst busy",   32'(ifa.busy),   32'd0);
    check("rst done",   32'(ifa.done),   32'd0);
    check("rst result", 32'(ifa.result), 32'd0);
    check("rst curr_a", 32'(ifa.curr_a), 32'd0);
    check("rst b done", 32'(ifb.done),   32'd0);
    reset = 1'b0;
    tick();
    check("idle busy", 32'(ifa.busy), 32'd0);

    run_a("ones 24",  1'b0, 8'b0010_0100, 2, 7);
    run_a("zeros F0", 1'b1, 8'b1111_0000, 4, 5);
    run_a("zeros FF", 1'b1, 8'hFF,        0, 1);
    run_a("ones 00",  1'b0, 8'h00,        0, 1);
    run_a("ones FF",  1'b0, 8'hFF,        8, 9);

    run_b("b FFFF", 16'hFFFF, 16, 5);
    run_b("b 0001", 16'h0001, 1,  2);

    // Reset during the third COUNT cycle aborts the count
    ifa.mode    = 1'b0;
    ifa.data_in = 8'b0010_0100;
    ifa.start   = 1'b1;
    tick();
    tick();
    tick();
    check("abort busy before", 32'(ifa.busy), 32'd1);
    reset     = 1'b1;
    ifa.start = 1'b0;
    tick();
    check("abort busy",   32'(ifa.busy),   32'd0);
    check("abort done",   32'(ifa.done),   32'd0);
    check("abort result", 32'(ifa.result), 32'd0);
    check("abort curr_a", 32'(ifa.curr_a), 32'd0);
    reset = 1'b0;
    tick();
    run_a("after abort", 1'b0, 8'b0101_0101, 4, 8);

    // Start held through DONE; data_in changes mid-COUNT
    ifa.mode    = 1'b0;
    ifa.data_in = 8'b1000_0001;
    ifa.start   = 1'b1;
    tick();
    tick();
    ifa.data_in = 8'hFF;
    n = 1;
    while (!ifa.done && n < 40) begin
      tick();
      n++;
    end
    check("hold latency", 32'(n), 32'd9);
    check("hold result",  32'(ifa.result), 32'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold done",   32'(ifa.done),   32'd1);
      check("hold reload", 32'(ifa.curr_a), 32'd0);
      check("hold res",    32'(ifa.result), 32'd2);
    end
    ifa.start = 1'b0;
    tick();
    check("hold drop done", 32'(ifa.done), 32'd0);
    check("hold drop busy", 32'(ifa.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
